// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared fetch-sequencer types and default widths
package proc_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch target table, one sync write port, one async read port
module branch_lut #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [LUT_AW-1:0] waddr_i,
  input  logic [PC_W-1:0]   wdata_i,
  input  logic [LUT_AW-1:0] raddr_i,
  output logic [PC_W-1:0]   rdata_o
);

  logic [PC_W-1:0] mem_q [2**LUT_AW];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2**LUT_AW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write lands only on the next read
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter with LUT-redirected branches and Start/Done handshake
module pc_branch_ctrl
  import proc_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              branch_en_i,
  input  logic              taken_i,
  input  logic [LUT_AW-1:0] tgt_idx_i,
  input  logic              halt_i,
  input  logic              lut_we_i,
  input  logic [LUT_AW-1:0] lut_waddr_i,
  input  logic [PC_W-1:0]   lut_wdata_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              done_o,
  output logic              running_o
);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_rdata;
  logic            start_q;
  logic            done_q;
  logic            running_q;

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (lut_we_i),
    .waddr_i (lut_waddr_i),
    .wdata_i (lut_wdata_i),
    .raddr_i (tgt_idx_i),
    .rdata_o (lut_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        // Falling edge of Start launches the program; start_q is cleared by reset
        if (!start_i && start_q) state_d = RUN;
      end
      RUN: begin
        if (start_i) begin
          state_d = IDLE;
          pc_d    = '0;
        end else if (halt_i) begin
          state_d = DONE;
        end else if (branch_en_i && taken_i) begin
          pc_d = lut_rdata;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (start_i) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      start_q   <= start_i;
      done_q    <= (state_d == DONE);
      running_q <= (state_d == RUN);
    end
  end

  assign pc_o      = pc_q;
  assign done_o    = done_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - vector table and scoreboard bench for pc_branch_ctrl
module tb_pc_branch_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;

  typedef struct {
    logic              rst;
    logic              start;
    logic              br;
    logic              tk;
    logic [LUT_AW-1:0] idx;
    logic              halt;
    logic              we;
    logic [LUT_AW-1:0] wa;
    logic [PC_W-1:0]   wd;
    logic [PC_W-1:0]   pc;
    logic              done;
    logic              run;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            done;
    logic            run;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic              branch_en;
  logic              taken;
  logic [LUT_AW-1:0] tgt_idx;
  logic              halt;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              done;
  logic              running;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_total;
  int   n_pass;

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .branch_en_i (branch_en),
    .taken_i     (taken),
    .tgt_idx_i   (tgt_idx),
    .halt_i      (halt),
    .lut_we_i    (lut_we),
    .lut_waddr_i (lut_waddr),
    .lut_wdata_i (lut_wdata),
    .pc_o        (pc),
    .done_o      (done),
    .running_o   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic st, input logic br, input logic tk,
                              input int idx, input logic hl, input logic we, input int wa,
                              input int wd, input int epc, input logic ed, input logic er);
    vec_t v;
    v.rst = rst; v.start = st; v.br = br; v.tk = tk; v.idx = LUT_AW'(idx);
    v.halt = hl; v.we = we; v.wa = LUT_AW'(wa); v.wd = PC_W'(wd);
    v.pc = PC_W'(epc); v.done = ed; v.run = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    reset = v.rst; start = v.start; branch_en = v.br; taken = v.tk; tgt_idx = v.idx;
    halt = v.halt; lut_we = v.we; lut_waddr = v.wa; lut_wdata = v.wd;
    e.pc = v.pc; e.done = v.done; e.run = v.run;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " pc"}, int'(pc), int'(e.pc));
    check({tag, " done"}, int'(done), int'(e.done));
    check({tag, " running"}, int'(running), int'(e.run));
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b1; start = 1'b1; branch_en = 1'b0; taken = 1'b0; tgt_idx = '0;
    halt = 1'b1; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;

    //                rst st br tk idx hl we wa  wd   pc  dn rn
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0,    0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0,    0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 200,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 9,    0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  0, 1));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, i,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,    5,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    5,  1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,    0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  0, 1));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, i,  0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0, 0,  200,  0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3, 0, 0, 0, 0,  201,  0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 0,  202,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 7,  203,  0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 0, 0, 0,    7,  0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4, 0, 0, 0, 0,    8,  0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, 1, 2, 50,   9,  0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 0, 0,   50,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1023, 51, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1023,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    1,  0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 3, 1, 0, 0, 0,    1,  1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0, 0,    1,  1, 0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Abort mid-run at PC 40: no Done, PC back to 0
    step(mk(0, 1, 0, 0, 0, 0, 1, 6, 40, 0, 0, 0), "abort_idle");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1), "abort_go");
    step(mk(0, 0, 1, 1, 6, 0, 0, 0, 0, 40, 0, 1), "abort_br40");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0), "abort_start");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0), "abort_hold");

    // Reset while DONE, then confirm the LUT was cleared
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1), "rd_go");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1), "rd_pc1");
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0), "rd_halt");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0), "rd_reset");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0), "rd_start");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1), "rd_go2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1), "rd_pc1b");
    step(mk(0, 0, 1, 1, 3, 0, 0, 0, 0,  0, 0, 1), "rd_lut3");
    step(mk(0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1), "rd_lut1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
